// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame state encoding,
// parity-type codes and serial line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity generator: captures the parity of the payload on the
// accept strobe so it stays fixed for the whole frame.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int WIDTH_DATA = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH_DATA-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_TYP,
    output logic                  par_bit
);

    // Odd parity is the complement of the even (XOR-reduce) result.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit <= 1'b0;
        end else if (DATA_VALID) begin
            par_bit <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: latches a byte, sequences start, data,
// optional parity and stop bits, and gates the external serializer.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int WIDTH_DATA = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH_DATA-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [WIDTH_DATA-1:0] SER_P_DATA,
    output logic                  ser_en,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   par_en_q;
    logic   par_bit;

    // A new byte is only taken when the line is idle or finishing a stop bit.
    assign accept = DATA_VALID && ((state == IDLE) || (state == STOP));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            SER_P_DATA <= '0;
            par_en_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                SER_P_DATA <= P_DATA;
                par_en_q   <= PAR_EN;
            end
        end
    end

    uart_parity_calc #(
        .WIDTH_DATA(WIDTH_DATA)
    ) u_parity (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(accept),
        .PAR_TYP   (PAR_TYP),
        .par_bit   (par_bit)
    );

    always_comb begin
        next_state = state;
        TX_OUT     = IDLE_BIT;
        BUSY       = 1'b0;
        ser_en     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = START;
                end
            end
            START: begin
                TX_OUT     = START_BIT;
                BUSY       = 1'b1;
                next_state = DATA;
            end
            DATA: begin
                TX_OUT = ser_data;
                BUSY   = 1'b1;
                ser_en = 1'b1;
                if (ser_done) begin
                    next_state = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                TX_OUT     = par_bit;
                BUSY       = 1'b1;
                next_state = STOP;
            end
            STOP: begin
                TX_OUT     = STOP_BIT;
                BUSY       = 1'b1;
                next_state = accept ? START : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl with a behavioural serializer
// and a frame-level reference model built from the UART framing rules.
module tb_uart_tx_frame_ctrl;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [W-1:0] SER_P_DATA;
    logic         ser_en;
    logic         ser_data;
    logic         ser_done;
    logic         TX_OUT;
    logic         BUSY;

    int n_compared   = 0;
    int n_mismatched = 0;

    uart_tx_frame_ctrl #(.WIDTH_DATA(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .SER_P_DATA(SER_P_DATA),
        .ser_en    (ser_en),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer stand-in: bit index counts while enabled, clears otherwise.
    logic [2:0] ser_cnt;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)        ser_cnt <= '0;
        else if (ser_en) ser_cnt <= ser_cnt + 3'd1;
        else             ser_cnt <= '0;
    end
    assign ser_data = SER_P_DATA[ser_cnt];
    assign ser_done = ser_en && (ser_cnt == 3'(W - 1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_parity(input logic [W-1:0] d, input logic typ);
        return logic'(($countones(d) % 2) != 0) ^ typ;
    endfunction

    // Presents a byte for one edge; returns at the sample point of the start bit.
    task automatic start_frame(input logic [W-1:0] d, input logic pen, input logic typ);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = typ;
        DATA_VALID = 1'b1;
        @(negedge CLK);
    endtask

    // Walks one frame from its start bit, comparing every line cycle.
    task automatic check_frame(input logic [W-1:0] d, input logic pen, input logic exp_par,
                               input bit toggle_typ, input bit hold_dv,
                               input bit chain, input logic [W-1:0] next_d,
                               input logic next_pen, input logic next_typ);
        logic q[$];
        q.push_back(1'b0);
        for (int b = 0; b < W; b++) q.push_back(d[b]);
        if (pen) q.push_back(exp_par);
        q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("tx_out[%0d]", i), 32'(TX_OUT), 32'(q[i]));
            chk($sformatf("busy[%0d]", i), 32'(BUSY), 32'd1);
            chk($sformatf("ser_en[%0d]", i), 32'(ser_en), 32'((i >= 1) && (i <= W)));
            chk($sformatf("ser_p_data[%0d]", i), 32'(SER_P_DATA), 32'(d));
            if (i == 0 && !hold_dv) DATA_VALID = 1'b0;
            if (i == 3 && toggle_typ) PAR_TYP = ~PAR_TYP;
            if (i == 3 && hold_dv) P_DATA = 8'hEE;
            if (i == q.size() - 1) begin
                if (chain) begin
                    P_DATA     = next_d;
                    PAR_EN     = next_pen;
                    PAR_TYP    = next_typ;
                    DATA_VALID = 1'b1;
                end else begin
                    DATA_VALID = 1'b0;
                end
            end
            @(negedge CLK);
        end
        if (!chain) begin
            chk("idle_tx_out", 32'(TX_OUT), 32'd1);
            chk("idle_busy", 32'(BUSY), 32'd0);
            chk("idle_ser_en", 32'(ser_en), 32'd0);
        end
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic         pen;
        logic         typ;
        logic         exp_par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0};

        RST        = 1'b0;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        chk("rst_tx_out", 32'(TX_OUT), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ser_en", 32'(ser_en), 32'd0);
        chk("rst_ser_p_data", 32'(SER_P_DATA), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 6; v++) begin
            start_frame(vecs[v].d, vecs[v].pen, vecs[v].typ);
            check_frame(vecs[v].d, vecs[v].pen, vecs[v].exp_par, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end

        // Odd parity of 8'h01 with PAR_TYP flipped mid-data must still be 0.
        start_frame(8'h01, 1'b1, 1'b1);
        check_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Held strobe and a changed payload mid-frame are ignored; STOP accept chains.
        start_frame(8'h3C, 1'b1, 1'b0);
        check_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        check_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset on the 4th data cycle.
        start_frame(8'h96, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_ser_en", 32'(ser_en), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_tx_out", 32'(TX_OUT), 32'd1);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        chk("async_rst_ser_en", 32'(ser_en), 32'd0);
        chk("async_rst_ser_p_data", 32'(SER_P_DATA), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        start_frame(8'h5A, 1'b1, 1'b0);
        check_frame(8'h5A, 1'b1, model_parity(8'h5A, 1'b0), 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [W-1:0] d;
            logic         pen;
            logic         typ;
            d   = W'($urandom);
            pen = 1'($urandom);
            typ = 1'($urandom);
            start_frame(d, pen, typ);
            check_frame(d, pen, model_parity(d, typ), 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
UART transmit frame controller, directly upstream of and wrapped around the bit serializer.
- Accepts a parallel byte on DATA_VALID, latches it together with the parity configuration, and computes the parity bit.
- Sequences start, data, optional parity and stop bits onto TX_OUT, enabling the serializer only during the data phase.
- Drives BUSY back to the data source, so it sits between the TX clock-domain data source and the serial line.

Parameters:
WIDTH_DATA, 8, payload width in bits; also the number of data-phase cycles.

Ports:
CLK  input  1  TX bit clock (one bit per cycle)
RST  input  1  asynchronous, active-low reset
P_DATA  input  WIDTH_DATA  payload from upstream; sampled only on accept
DATA_VALID  input  1  payload-valid strobe from upstream
PAR_EN  input  1  1 = insert parity bit; sampled on accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept
SER_P_DATA  output  WIDTH_DATA  latched payload fed to the serializer's parallel input
ser_en  output  1  serializer enable
ser_data  input  1  current data bit from the serializer
ser_done  input  1  serializer last-bit flag (high during the final data cycle)
TX_OUT  output  1  serial line, idle high
BUSY  output  1  frame in progress

Behaviour:
- Reset (RST low, async):
  - state = IDLE, payload latch = 0, parity/config latches = 0.
  - Outputs: TX_OUT = 1, BUSY = 0, ser_en = 0, SER_P_DATA = 0.
- States: IDLE, START, DATA, PARITY, STOP. State is a register; all outputs are a combinational decode of state (Moore), except TX_OUT in DATA.
- Accept:
  - Occurs when DATA_VALID = 1 in IDLE or in STOP.
  - On that edge: latch P_DATA -> SER_P_DATA, latch PAR_EN, compute and latch the parity bit from the P_DATA value sampled at that edge.
  - Parity bit = XOR of all data bits when PAR_TYP = 0; its inverse when PAR_TYP = 1.
- DATA_VALID in START, DATA or PARITY is ignored; the latches hold.
- Changes to PAR_EN/PAR_TYP mid-frame do not affect the current frame.
- IDLE: TX_OUT = 1, BUSY = 0, ser_en = 0. Accept -> START; else stay.
- START: TX_OUT = 0, BUSY = 1, ser_en = 0. Unconditionally -> DATA.
- DATA:
  - Outputs: ser_en = 1, TX_OUT = ser_data, BUSY = 1.
  - The serializer counter is 0 on the first DATA cycle, so bits go out LSB first.
  - ser_done = 1 -> PARITY if latched PAR_EN = 1, else STOP.
  - ser_done = 0 -> stay.
- PARITY: TX_OUT = latched parity bit, BUSY = 1, ser_en = 0. -> STOP.
- STOP:
  - TX_OUT = 1, BUSY = 1, ser_en = 0.
  - Accept -> START (back-to-back frames, no idle gap); else -> IDLE.
- Latency:
  - The accept edge is followed by the start bit on the next cycle.
  - Frame length = 1 + WIDTH_DATA + PAR_EN + 1 cycles.
- ser_en deasserts on the cycle after ser_done, which also clears the serializer counter.
- Reset mid-frame:
  - Immediate return to IDLE; TX_OUT = 1 with no glitch-low.
  - The partial frame is abandoned; the upstream source must re-present it.
- ser_en must never be high outside DATA; TX_OUT must never be X after reset.

Decomposition:
- Shared package (uart_tx_pkg):
  - state encoding constants: IDLE = 3'b000, START = 3'b001, DATA = 3'b011, PARITY = 3'b010, STOP = 3'b110
  - PAR_EVEN = 1'b0, PAR_ODD = 1'b1
  - line levels: IDLE_BIT = 1'b1, START_BIT = 1'b0, STOP_BIT = 1'b1
- One sub-module: uart_parity_calc.
  - Inputs: P_DATA, DATA_VALID, PAR_TYP, CLK, RST.
  - Output: registered parity bit, latched on DATA_VALID.
- FSM and output mux stay in the top.

Test Plan:
- Frame with even parity:
  - Stimulus: reset, then P_DATA = 8'hA5, PAR_EN = 1, PAR_TYP = 0, 1-cycle DATA_VALID in IDLE.
  - Response: TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, then 1.
  - BUSY is high for exactly those 11 cycles; ser_en is high only for the 8 data cycles.
- Frame with odd parity, no change during frame:
  - Stimulus: P_DATA = 8'h01, PAR_EN = 1, PAR_TYP = 1; toggle PAR_TYP during DATA.
  - Response: parity bit = 0 (odd parity of a single 1); the toggle has no effect.
- Frame without parity:
  - Stimulus: P_DATA = 8'hFF, PAR_EN = 0.
  - Response: 10-cycle frame 0,1,1,1,1,1,1,1,1,1; STOP follows directly after the 8th data bit.
- Back-to-back frames and ignored strobe:
  - Stimulus: DATA_VALID held high with 8'h3C, then 8'hC3 presented in the STOP cycle; also pulse DATA_VALID during DATA.
  - Response: the second frame's start bit immediately follows STOP; BUSY never drops; the mid-frame strobe is ignored and SER_P_DATA holds 8'h3C until the STOP-cycle accept.
- Reset mid-frame:
  - Stimulus: assert RST on the 4th data cycle.
  - Response: TX_OUT = 1, BUSY = 0, ser_en = 0 immediately (asynchronously); after release, a new 8'h5A frame transmits correctly.
